// File: rtl/uart_tx.sv
// UART transmitter: accepts a word over valid/ready and shifts out start bit,
// LSB-first data, optional parity and one or two stop bits.
module uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    logic [BAUD_W-1:0]     r_baud;
    logic [BIT_W-1:0]      r_bit;
    logic [DATA_BITS-1:0]  r_shift;
    logic                  r_parity;
    logic                  r_tx;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_wrap;
    logic                  w_ready;
    logic                  w_accept;

    assign w_wrap   = (r_baud == BAUD_LAST);
    assign w_ready  = (r_state == S_IDLE) && !reset;
    assign w_accept = tx_valid && w_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    r_baud <= '0;
                    r_bit  <= '0;
                    if (w_accept) begin
                        // Parity is frozen with the data so later tx_data changes cannot leak in.
                        r_shift  <= tx_data;
                        r_parity <= (^tx_data) ^ (PARITY_ODD != 0);
                        r_state  <= S_START;
                        r_tx     <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end

                S_START: begin
                    if (w_wrap) begin
                        r_baud  <= '0;
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                S_DATA: begin
                    if (w_wrap) begin
                        r_baud <= '0;
                        if (r_bit == DATA_LAST) begin
                            r_bit <= '0;
                            if (PARITY_EN != 0) begin
                                r_state <= S_PARITY;
                                r_tx    <= r_parity;
                            end else begin
                                r_state <= S_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            // tx is registered, so it takes the bit that becomes LSB after this shift.
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                S_PARITY: begin
                    if (w_wrap) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                S_STOP: begin
                    r_tx <= 1'b1;
                    // Registered pulse: armed one cycle early so it lands on the final stop cycle.
                    if ((r_bit == STOP_LAST) && (r_baud == BAUD_PRE)) begin
                        r_done <= 1'b1;
                    end
                    if (w_wrap) begin
                        r_baud <= '0;
                        if (r_bit == STOP_LAST) begin
                            r_bit   <= '0;
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_baud  <= '0;
                    r_bit   <= '0;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready = w_ready;
    assign tx       = r_tx;
    assign busy     = r_busy;
    assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations side by side, each frame checked
// cycle by cycle against a waveform built from the framing rules.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] d_valid = 4'b0000;
    logic [8:0] d_data [4];
    wire  [3:0] o_tx;
    wire  [3:0] o_busy;
    wire  [3:0] o_done;
    wire  [3:0] o_ready;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    int cpb     [4] = '{4, 4, 4, 3};
    int nbits   [4] = '{8, 8, 8, 7};
    int par_en  [4] = '{0, 1, 1, 0};
    int par_odd [4] = '{0, 0, 1, 0};
    int stops   [4] = '{1, 1, 1, 2};

    bit   exp_q[$];
    logic obs_q[$];

    always #5 clk = ~clk;

    uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
        .clk(clk), .reset(reset), .tx_data(d_data[0][7:0]), .tx_valid(d_valid[0]),
        .tx_ready(o_ready[0]), .tx(o_tx[0]), .busy(o_busy[0]), .tx_done(o_done[0]));
    uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u1 (
        .clk(clk), .reset(reset), .tx_data(d_data[1][7:0]), .tx_valid(d_valid[1]),
        .tx_ready(o_ready[1]), .tx(o_tx[1]), .busy(o_busy[1]), .tx_done(o_done[1]));
    uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u2 (
        .clk(clk), .reset(reset), .tx_data(d_data[2][7:0]), .tx_valid(d_valid[2]),
        .tx_ready(o_ready[2]), .tx(o_tx[2]), .busy(o_busy[2]), .tx_done(o_done[2]));
    uart_tx #(.CLKS_PER_BIT(3), .DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u3 (
        .clk(clk), .reset(reset), .tx_data(d_data[3][6:0]), .tx_valid(d_valid[3]),
        .tx_ready(o_ready[3]), .tx(o_tx[3]), .busy(o_busy[3]), .tx_done(o_done[3]));

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected line level for every cycle of one frame, from the framing rules.
    task automatic build(input int id, input logic [8:0] data);
        int ones;
        bit p;
        ones = 0;
        exp_q.delete();
        for (int c = 0; c < cpb[id]; c++) exp_q.push_back(1'b0);
        for (int i = 0; i < nbits[id]; i++) begin
            if (data[i]) ones++;
            for (int c = 0; c < cpb[id]; c++) exp_q.push_back(data[i]);
        end
        if (par_en[id] != 0) begin
            p = (par_odd[id] != 0) ? (ones % 2 == 0) : (ones % 2 == 1);
            for (int c = 0; c < cpb[id]; c++) exp_q.push_back(p);
        end
        for (int c = 0; c < stops[id] * cpb[id]; c++) exp_q.push_back(1'b1);
    endtask

    task automatic start(input int id, input logic [8:0] data);
        @(negedge clk);
        d_data[id]  = data;
        d_valid[id] = 1'b1;
        chk("ready_before_handshake", o_ready[id], 1'b1);
    endtask

    // Checks cycles 1..n after a handshake; optionally keeps tx_valid high,
    // rewrites tx_data mid-frame, or pulses a stray tx_valid at cycle pulse_k.
    task automatic frame(input int id, input logic [8:0] data, input logic [8:0] mid_data,
                         input bit keep, input int pulse_k, input int ncyc);
        int n;
        build(id, data);
        obs_q.delete();
        n = (ncyc == 0) ? exp_q.size() : ncyc;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            obs_q.push_back(o_tx[id]);
            if (o_done[id] === 1'b1) done_seen++;
            chk("frame_tx", o_tx[id], exp_q[k-1]);
            chk("frame_busy", o_busy[id], 1'b1);
            chk("frame_done", o_done[id], k == exp_q.size());
            chk("frame_ready", o_ready[id], 1'b0);
            if (k == 1 && !keep) d_valid[id] = 1'b0;
            if (k == exp_q.size() / 2) d_data[id] = mid_data;
            if (pulse_k != 0 && k == pulse_k) begin
                d_valid[id] = 1'b1;
                d_data[id]  = 9'h0FF;
            end
            if (pulse_k != 0 && k == pulse_k + 1) d_valid[id] = 1'b0;
        end
    endtask

    task automatic after_frame(input int id);
        @(negedge clk);
        if (o_done[id] === 1'b1) done_seen++;
        chk("post_tx", o_tx[id], 1'b1);
        chk("post_busy", o_busy[id], 1'b0);
        chk("post_done", o_done[id], 1'b0);
        chk("post_ready", o_ready[id], 1'b1);
    endtask

    task automatic idle(input int id, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (o_done[id] === 1'b1) done_seen++;
            chk("idle_tx", o_tx[id], 1'b1);
            chk("idle_busy", o_busy[id], 1'b0);
            chk("idle_done", o_done[id], 1'b0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [8:0] rnd;
        for (int i = 0; i < 4; i++) d_data[i] = 9'h000;

        // Reset state, and reset winning over tx_valid.
        @(negedge clk);
        @(negedge clk);
        chk("rst_tx", o_tx[0], 1'b1);
        chk("rst_busy", o_busy[0], 1'b0);
        chk("rst_done", o_done[0], 1'b0);
        chk("rst_ready", o_ready[0], 1'b0);
        d_valid[0] = 1'b1;
        d_data[0]  = 9'h0A5;
        @(negedge clk);
        chk("rstvalid_busy", o_busy[0], 1'b0);
        chk("rstvalid_tx", o_tx[0], 1'b1);
        chk("rstvalid_ready", o_ready[0], 1'b0);
        reset      = 1'b0;
        d_valid[0] = 1'b0;
        @(negedge clk);
        chk("release_ready", o_ready[0], 1'b1);
        chk("release_busy", o_busy[0], 1'b0);

        // Basic 0xA5 frame, tx_data disturbed mid-frame.
        start(0, 9'h0A5);
        frame(0, 9'h0A5, 9'h05A, 1'b0, 0, 0);
        after_frame(0);
        chk("a5_start", obs_q[0], 1'b0);
        chk("a5_bit0", obs_q[4], 1'b1);
        chk("a5_bit1", obs_q[8], 1'b0);
        chk("a5_bit7", obs_q[32], 1'b1);

        // Parity bit occupies cycles 37..40.
        start(1, 9'h007);
        frame(1, 9'h007, 9'h000, 1'b0, 0, 0);
        after_frame(1);
        chk("parity_even_07", obs_q[36], 1'b1);
        start(2, 9'h007);
        frame(2, 9'h007, 9'h000, 1'b0, 0, 0);
        after_frame(2);
        chk("parity_odd_07", obs_q[36], 1'b0);
        start(1, 9'h000);
        frame(1, 9'h000, 9'h0FF, 1'b0, 0, 0);
        after_frame(1);
        chk("parity_even_00", obs_q[36], 1'b0);

        // Back-to-back with tx_valid held: second frame starts at cycle 42.
        base = done_seen;
        start(0, 9'h055);
        frame(0, 9'h055, 9'h0AA, 1'b1, 0, 0);
        after_frame(0);
        frame(0, 9'h0AA, 9'h0AA, 1'b0, 0, 0);
        after_frame(0);
        idle(0, 20);
        chk_int("b2b_done_pulses", done_seen - base, 2);

        // Stray tx_valid while busy is dropped.
        base = done_seen;
        start(0, 9'h03C);
        frame(0, 9'h03C, 9'h0C3, 1'b0, 10, 0);
        after_frame(0);
        idle(0, 60);
        chk_int("busy_ignore_done_pulses", done_seen - base, 1);

        // Reset during data bit 3 (cycles 17..20).
        base = done_seen;
        rnd = 9'($urandom_range(0, 255));
        start(0, rnd);
        frame(0, rnd, rnd, 1'b0, 0, 18);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_tx", o_tx[0], 1'b1);
        chk("midrst_busy", o_busy[0], 1'b0);
        chk("midrst_done", o_done[0], 1'b0);
        chk("midrst_ready", o_ready[0], 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_ready_after", o_ready[0], 1'b1);
        idle(0, 45);
        chk_int("midrst_no_done", done_seen - base, 0);
        start(0, 9'h081);
        frame(0, 9'h081, 9'h07E, 1'b0, 0, 0);
        after_frame(0);

        // Seven data bits, two stop bits, three clocks per bit.
        start(3, 9'h041);
        frame(3, 9'h041, 9'h03E, 1'b0, 0, 0);
        after_frame(3);
        chk_int("two_stop_frame_len", obs_q.size(), 30);
        for (int k = 24; k < 30; k++) chk("two_stop_level", obs_q[k], 1'b1);

        // Random words on every configuration.
        for (int r = 0; r < 16; r++) begin
            int id;
            id  = r % 4;
            rnd = 9'($urandom_range(0, 511));
            start(id, rnd);
            frame(id, rnd, 9'($urandom_range(0, 511)), 1'b0, 0, 0);
            after_frame(id);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
